// File: rtl/cpu_sram_arbiter_pkg.sv
// Shared constants and response record for the IF/EX single-port SRAM arbiter.
package cpu_sram_arbiter_pkg;

  localparam int unsigned PKG_ADDR_W = 32;
  localparam int unsigned PKG_DATA_W = 32;
  localparam int unsigned WE_W       = 4;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  // One in-flight SRAM access, captured at grant time.
  typedef struct packed {
    logic valid;
    logic owner;
    logic rd;
  } resp_t;

endpackage

// File: rtl/cpu_sram_arb_core.sv
// Per-cycle grant logic: data priority, bounded by a streak limit while a fetch waits.
module cpu_sram_arb_core
  import cpu_sram_arbiter_pkg::*;
#(
  parameter int unsigned MAX_DATA_STREAK = 4,
  parameter int unsigned STREAK_W        = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic inst_req,
  input  logic data_req,
  output logic gnt_inst,
  output logic gnt_data
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  logic [STREAK_W-1:0] streak;
  logic [STREAK_W-1:0] streak_d;

  always_comb begin
    gnt_data = 1'b0;
    gnt_inst = 1'b0;
    streak_d = streak;
    if (resetn) begin
      gnt_data = data_req && !(inst_req && streak == STREAK_MAX);
      gnt_inst = inst_req && !gnt_data;
    end
    // The streak only counts data wins that made a waiting fetch wait longer.
    if (!inst_req || gnt_inst) begin
      streak_d = '0;
    end else if (gnt_data && streak != STREAK_MAX) begin
      streak_d = streak + STREAK_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      streak <= '0;
    end else begin
      streak <= streak_d;
    end
  end

endmodule

// File: rtl/cpu_sram_arbiter.sv
// Shares one single-port SRAM between instruction fetch and data access, routing responses back.
module cpu_sram_arbiter
  import cpu_sram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W          = PKG_ADDR_W,
  parameter int unsigned DATA_W          = PKG_DATA_W,
  parameter int unsigned MAX_DATA_STREAK = 4,
  parameter int unsigned STREAK_W        = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic [WE_W-1:0]   data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              sram_en,
  output logic [WE_W-1:0]   sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  logic  gnt_inst;
  logic  gnt_data;
  resp_t resp_d;
  resp_t resp_q;

  cpu_sram_arb_core #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK),
    .STREAK_W       (STREAK_W)
  ) u_core (
    .clk     (clk),
    .resetn  (resetn),
    .inst_req(inst_req),
    .data_req(data_req),
    .gnt_inst(gnt_inst),
    .gnt_data(gnt_data)
  );

  assign inst_addr_ok = gnt_inst;
  assign data_addr_ok = gnt_data;

  // SRAM request mux; an idle cycle drives an all-zero request.
  always_comb begin
    sram_en    = gnt_inst | gnt_data;
    sram_we    = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (gnt_data) begin
      sram_we    = data_we;
      sram_addr  = data_addr;
      sram_wdata = data_wdata;
    end else if (gnt_inst) begin
      sram_addr = inst_addr;
    end
  end

  always_comb begin
    resp_d.valid = sram_en;
    resp_d.owner = gnt_data ? OWNER_DATA : OWNER_INST;
    resp_d.rd    = (sram_we == '0);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resp_q <= '0;
    end else begin
      resp_q <= resp_d;
    end
  end

  // Read data is steered to the owner recorded one cycle earlier.
  always_comb begin
    inst_data_ok = resp_q.valid && (resp_q.owner == OWNER_INST);
    data_data_ok = resp_q.valid && (resp_q.owner == OWNER_DATA);
    inst_rdata   = inst_data_ok ? sram_rdata : '0;
    data_rdata   = (data_data_ok && resp_q.rd) ? sram_rdata : '0;
  end

endmodule
